// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, byte-addressed read cache with line refill.
// Optional macro CACHE_STATS_EN adds saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 8,
    parameter int LINE_BYTES = 4,
    parameter int NUM_LINES  = 4096
`ifdef CACHE_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
`endif
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REFILL,
        RESPOND
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [OFF_W-1:0]    beat_q;
    logic [OFF_W-1:0]    beat_d;
    logic                pend_q;
    logic [NUM_LINES-1:0] valid_q;
    logic                ready_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                hit_q;
    logic                mreq_q;
    logic [ADDR_W-1:0]   maddr_q;

    logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
    logic [DATA_W-1:0]   data_mem [NUM_LINES*LINE_BYTES];

    logic [TAG_W-1:0]    tag_a;
    logic [IDX_W-1:0]    idx_a;
    logic [OFF_W-1:0]    off_a;
    logic                line_hit;
    logic                beat_ack;
    logic                last_beat;
    logic [DATA_W-1:0]   rd_byte;

    assign tag_a     = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_a     = addr_q[OFF_W +: IDX_W];
    assign off_a     = addr_q[OFF_W-1:0];
    assign line_hit  = valid_q[idx_a] && (tag_mem[idx_a] == tag_a);
    assign beat_ack  = (state_q == REFILL) && mem_ack;
    assign last_beat = (beat_q == OFF_W'(LINE_BYTES - 1));
    assign beat_d    = beat_q + OFF_W'(1);
    assign rd_byte   = data_mem[{idx_a, off_a}];

    assign cpu_ready = ready_q;
    assign cpu_rdata = rdata_q;
    assign cpu_hit   = hit_q;
    assign busy      = (state_q != IDLE);
    assign mem_req   = mreq_q;
    assign mem_addr  = maddr_q;

`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    // Line storage: bytes written per refill beat, tag on the final beat.
    always_ff @(posedge clk) begin
        if (beat_ack) begin
            data_mem[{idx_a, beat_q}] <= mem_rdata;
            if (last_beat) begin
                tag_mem[idx_a] <= tag_a;
            end
        end
    end

    // Control FSM with registered CPU/memory outputs and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
            valid_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            mreq_q  <= 1'b0;
            maddr_q <= '0;
`ifdef CACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            if (flush && state_q != IDLE) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (flush || pend_q) begin
                        valid_q <= '0;
                        pend_q  <= 1'b0;
`ifdef CACHE_STATS_EN
                        hit_cnt_q  <= '0;
                        miss_cnt_q <= '0;
`endif
                    end else if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (line_hit) begin
                        rdata_q <= rd_byte;
                        hit_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
`ifdef CACHE_STATS_EN
                        if (hit_cnt_q != '1) begin
                            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        end
`endif
                    end else begin
                        beat_q  <= '0;
                        mreq_q  <= 1'b1;
                        maddr_q <= {tag_a, idx_a, {OFF_W{1'b0}}};
                        state_q <= REFILL;
`ifdef CACHE_STATS_EN
                        if (miss_cnt_q != '1) begin
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        end
`endif
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        beat_q <= beat_d;
                        if (last_beat) begin
                            mreq_q         <= 1'b0;
                            valid_q[idx_a] <= 1'b1;
                            state_q        <= RESPOND;
                        end else begin
                            maddr_q <= {tag_a, idx_a, beat_d};
                        end
                    end
                end
                RESPOND: begin
                    rdata_q <= rd_byte;
                    hit_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
